// File: rtl/edge_frame_display.sv
// edge_frame_display: stores Sobel edge bits in a two-bank frame store and paints them into a window of the LCD raster.
// Latency: pix_data follows (pix_x, pix_y) by exactly 2 cycles; an accepted edge bit is written 1 cycle after edge_valid.
// Backpressure: none; edge_valid is never stalled. A whole frame that arrives while another is still waiting to be shown is dropped and counted.
module edge_frame_display #(
  parameter int          HOR_SCREEN  = 800,
  parameter int          VERT_SCREEN = 480,
  parameter int          HOR_PIC     = 160,
  parameter int          VERT_PIC    = 160,
  parameter int          X_START     = 321,
  parameter int          Y_START     = 161,
  parameter logic [15:0] FG_COLOR    = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter logic [15:0] OUT_COLOR   = 16'h001F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        edge_in,
  input  logic        edge_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        has_frame,
  output logic        frame_drop,
  output logic [7:0]  dropped_cnt
);

  localparam int EDGE_W = HOR_PIC - 2;
  localparam int EDGE_H = VERT_PIC - 2;
  localparam int NPIX   = EDGE_W * EDGE_H;
  localparam int AW     = $clog2(NPIX);
  localparam int CW     = $clog2(EDGE_W);
  localparam int RW     = $clog2(EDGE_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(EDGE_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(EDGE_H - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(EDGE_W);
  localparam logic [9:0]    X_LO      = 10'(X_START);
  localparam logic [9:0]    X_HI      = 10'(X_START + EDGE_W);
  localparam logic [9:0]    Y_LO      = 10'(Y_START);
  localparam logic [9:0]    Y_HI      = 10'(Y_START + EDGE_H);
  localparam logic [9:0]    X_SCR     = 10'(HOR_SCREEN);
  localparam logic [9:0]    Y_SCR     = 10'(VERT_SCREEN);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pending_q, pending_d;
  logic          armed_q, armed_d;
  logic          has_frame_q, has_frame_d;
  logic          frame_drop_q, frame_drop_d;
  logic [7:0]    dropped_cnt_q, dropped_cnt_d;
  logic          in_win_q, in_win_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          rbit_q;

  logic          at_origin, at_last, arm_now, wr_en, swap;
  logic [9:0]    dx, dy;
  logic [AW-1:0] rd_addr;

  logic          mem0 [NPIX];
  logic          mem1 [NPIX];

  // Write position, frame arming, drop accounting and bank swap
  always_comb begin
    at_origin     = (col_q == '0) && (row_q == '0);
    at_last       = (col_q == COL_LAST) && (row_q == ROW_LAST);
    // A frame is only accepted if it starts while no finished frame is waiting.
    arm_now       = armed_q || (!pending_q && at_origin);
    wr_en         = edge_valid && arm_now;
    swap          = (pix_x == '0) && (pix_y == '0) && pending_q;

    col_d         = col_q;
    row_d         = row_q;
    waddr_d       = waddr_q;
    armed_d       = arm_now;
    pending_d     = pending_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    has_frame_d   = has_frame_q;
    frame_drop_d  = 1'b0;
    dropped_cnt_d = dropped_cnt_q;

    if (edge_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      waddr_d = at_last ? '0 : waddr_q + AW'(1);
    end

    if (swap) begin
      rd_bank_d   = wr_bank_q;
      wr_bank_d   = !wr_bank_q;
      pending_d   = 1'b0;
      has_frame_d = 1'b1;
    end

    // Last pixel: either close the captured frame or count a discarded one.
    if (edge_valid && at_last) begin
      if (arm_now) begin
        armed_d   = 1'b0;
        pending_d = 1'b1;
      end else if (pending_q) begin
        frame_drop_d = 1'b1;
        if (dropped_cnt_q != 8'hFF) begin
          dropped_cnt_d = dropped_cnt_q + 8'd1;
        end
      end
    end
  end

  // Window decode and read address for the requested screen pixel
  always_comb begin
    dx       = pix_x - X_LO;
    dy       = pix_y - Y_LO;
    in_win_d = (pix_x >= X_LO) && (pix_x < X_HI) && (pix_x < X_SCR) &&
               (pix_y >= Y_LO) && (pix_y < Y_HI) && (pix_y < Y_SCR);
    rd_addr  = '0;
    if (in_win_d) begin
      rd_addr = AW'(dy) * ROW_PITCH + AW'(dx);
    end
  end

  // Colour for the pixel whose window flag and stored bit arrived last cycle
  always_comb begin
    pix_data_d = OUT_COLOR;
    if (in_win_q) begin
      pix_data_d = (has_frame_q && rbit_q) ? FG_COLOR : BG_COLOR;
    end
  end

  // Frame store: one write port into wr_bank, one registered read port from rd_bank
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) begin
        mem1[waddr_q] <= edge_in;
      end else begin
        mem0[waddr_q] <= edge_in;
      end
    end
    rbit_q <= rd_bank_q ? mem1[rd_addr] : mem0[rd_addr];
  end

  // Control and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      waddr_q       <= '0;
      wr_bank_q     <= 1'b1;
      rd_bank_q     <= 1'b0;
      pending_q     <= 1'b0;
      armed_q       <= 1'b1;
      has_frame_q   <= 1'b0;
      frame_drop_q  <= 1'b0;
      dropped_cnt_q <= '0;
      in_win_q      <= 1'b0;
      pix_data_q    <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      waddr_q       <= waddr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      pending_q     <= pending_d;
      armed_q       <= armed_d;
      has_frame_q   <= has_frame_d;
      frame_drop_q  <= frame_drop_d;
      dropped_cnt_q <= dropped_cnt_d;
      in_win_q      <= in_win_d;
      pix_data_q    <= pix_data_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign has_frame   = has_frame_q;
  assign frame_drop  = frame_drop_q;
  assign dropped_cnt = dropped_cnt_q;

endmodule

// File: tb/tb_edge_frame_display.sv
// tb_edge_frame_display: random pixel requests and edge frames against an image-level model of the display.
// Latency: expected colours are queued at request time and popped when the 2-cycle pipeline delivers them.
// Backpressure: none; the bench drives one request and at most one edge pixel per cycle.
module tb_edge_frame_display;

  localparam int EW   = 158;
  localparam int EH   = 158;
  localparam int NPIX = EW * EH;
  localparam int XS   = 321;
  localparam int YS   = 161;

  logic        clk = 1'b0;
  logic        rst;
  logic        edge_in;
  logic        edge_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        has_frame;
  logic        frame_drop;
  logic [7:0]  dropped_cnt;

  always #5 clk = ~clk;

  edge_frame_display dut (
    .clk        (clk),
    .rst        (rst),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .has_frame  (has_frame),
    .frame_drop (frame_drop),
    .dropped_cnt(dropped_cnt)
  );

  // Image-level model: the shown picture, the finished picture waiting for (0,0), and the one being received.
  bit disp_img [NPIX];
  bit wait_img [NPIX];
  bit cur_img  [NPIX];
  bit pat      [NPIX];
  bit m_has, m_wait, m_capt;
  int m_pos, m_drops;

  logic [15:0] exp_q[$];
  logic        req_vld = 1'b0;
  logic [1:0]  vpipe   = 2'b00;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          drop_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int x, input int y);
    if (x >= XS && x < XS + EW && y >= YS && y < YS + EH)
      return (m_has && disp_img[(y - YS) * EW + (x - XS)]) ? 16'hFFFF : 16'h0000;
    return 16'h001F;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_wait = 0; m_has = 0; m_capt = 0; m_drops = 0;
  endtask

  // One clock cycle of stimulus; the model advances with the same inputs.
  task automatic cycle(input bit v, input bit b, input int x, input int y, input bit chk);
    bit old_wait;
    edge_valid = v;
    edge_in    = b;
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    req_vld    = chk;
    if (chk) exp_q.push_back(model_pix(x, y));
    old_wait = m_wait;
    if (v) begin
      if (m_pos == 0) m_capt = !old_wait;
      if (m_capt) cur_img[m_pos] = b;
      if (m_pos == NPIX - 1) begin
        if (m_capt) begin
          wait_img = cur_img;
          m_wait   = 1;
        end else if (old_wait) begin
          m_drops++;
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    if (x == 0 && y == 0 && old_wait) begin
      disp_img = wait_img;
      m_has    = 1;
      m_wait   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_xy(output int x, output int y);
    if ($urandom_range(3) != 0) begin
      x = $urandom_range(485, 315);
      y = $urandom_range(325, 155);
    end else begin
      x = $urandom_range(1023);
      y = $urandom_range(1023);
    end
    if (x == 0 && y == 0) x = 1;
  endtask

  task automatic request(input int x, input int y);
    cycle(1'b0, 1'b0, x, y, 1'b1);
  endtask

  task automatic rand_reads(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      rand_xy(x, y);
      cycle(1'b0, 1'(($urandom_range(1))), x, y, 1'b1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1, 1, 1'b0);
  endtask

  task automatic pulse_reset();
    drain();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1, 1, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  // Sends pat[] as one frame; gapped frames get random idle cycles in the top and bottom bands.
  task automatic write_frame(input bit gapped);
    int x, y, row;
    for (int p = 0; p < NPIX; p++) begin
      row = p / EW;
      if (gapped && (row < 16 || row >= EH - 16)) begin
        for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
          rand_xy(x, y);
          cycle(1'b0, 1'(($urandom_range(1))), x, y, 1'b1);
        end
      end
      rand_xy(x, y);
      cycle(1'b1, pat[p], x, y, 1'b1);
    end
  endtask

  // Expected colour pipeline tracks the DUT's fixed 2-cycle read latency.
  always @(posedge clk) vpipe <= {vpipe[0], req_vld};

  // Scoreboard monitor
  always @(negedge clk) begin
    if (vpipe[1]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: pix_data %0h presented with nothing expected", pix_data);
      end else begin
        check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) if (frame_drop) drop_pulses++;

  initial begin
    rst = 1'b1; edge_valid = 1'b0; edge_in = 1'b0; pix_x = '0; pix_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_data",    32'(pix_data),    32'h0);
    check("reset_has_frame",   32'(has_frame),   32'h0);
    check("reset_frame_drop",  32'(frame_drop),  32'h0);
    check("reset_dropped_cnt", 32'(dropped_cnt), 32'h0);
    rst = 1'b0;

    // Window before any frame, origin and off-screen request.
    request(321, 161);
    request(0, 0);
    request(900, 10);
    drain();
    check("init_has_frame", 32'(has_frame), 32'h0);

    // Partial frame of ones, then reset: it must not show up or shift later frames.
    for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, 1, 1, 1'b0);
    pulse_reset();
    check("post_rst_has_frame", 32'(has_frame), 32'h0);

    // Frame 1: ones only at the two corners, sent with random valid gaps.
    for (int i = 0; i < NPIX; i++) pat[i] = 1'b0;
    pat[0] = 1'b1;
    pat[NPIX - 1] = 1'b1;
    write_frame(1'b1);
    check("pending_has_frame", 32'(has_frame), 32'h0);

    // Frame 2 arrives with frame 1 still waiting: it is dropped.
    for (int i = 0; i < NPIX; i++) pat[i] = 1'(($urandom_range(1)));
    write_frame(1'b0);
    check("frame_drop_pulse", 32'(frame_drop), 32'h1);
    check("dropped_cnt", 32'(dropped_cnt), 32'(m_drops));

    // Swap shows frame 1.
    request(0, 0);
    check("swap_has_frame", 32'(has_frame), 32'h1);
    request(321, 161);
    request(322, 161);
    request(478, 318);
    request(320, 161);
    request(479, 318);
    rand_reads(300);
    drain();
    check("drop_pulses", 32'(drop_pulses), 32'h1);

    // Frame 3 with a one at (5,5): invisible until the next (0,0).
    for (int i = 0; i < NPIX; i++) pat[i] = 1'(($urandom_range(1)));
    pat[5 * EW + 5] = 1'b1;
    write_frame(1'b0);
    request(326, 166);
    check("no_swap_has_frame", 32'(has_frame), 32'h1);
    request(0, 0);
    request(326, 166);
    rand_reads(300);
    drain();
    check("dropped_cnt_final", 32'(dropped_cnt), 32'(m_drops));

    // Reset masks the stored picture.
    pulse_reset();
    check("rst2_has_frame", 32'(has_frame), 32'h0);
    check("rst2_dropped_cnt", 32'(dropped_cnt), 32'h0);
    request(326, 166);
    request(479, 318);
    rand_reads(50);
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_frame_display.md
Name: edge_frame_display

Overview:
- Display-side consumer of the Sobel edge stream: captures the 1-bit edge pixels qualified by the Sobel valid strobe into a double-buffered binary frame store.
- Reads the store back on demand from the LCD timing driver's pixel coordinates.
- Returns RGB565 colour for each screen pixel: edge picture window placed inside the panel, fixed colour elsewhere.
- Sits between the sobel block and the LCD driver, all in one clock domain.

Parameters:
- HOR_SCREEN, 800, active panel width in pixels
- VERT_SCREEN, 480, active panel height in pixels
- HOR_PIC, 160, source picture width; edge window width is EDGE_W = HOR_PIC-2 = 158
- VERT_PIC, 160, source picture height; edge window height is EDGE_H = VERT_PIC-2 = 158
- X_START, 321, screen column of edge window left edge
- Y_START, 161, screen row of edge window top edge
- FG_COLOR, 16'hFFFF, colour for edge bit 1
- BG_COLOR, 16'h0000, colour for edge bit 0, and for the whole window before the first complete frame
- OUT_COLOR, 16'h001F, colour outside the window

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- edge_in  in  1  edge bit from sobel
- edge_valid  in  1  edge_in qualifier; one pixel per high cycle, raster order
- pix_x  in  10  screen column requested by LCD driver, sampled every cycle
- pix_y  in  10  screen row requested by LCD driver, sampled every cycle
- pix_data  out  16  RGB565 for the (pix_x, pix_y) presented 2 cycles earlier
- has_frame  out  1  at least one complete frame has been swapped to display
- frame_drop  out  1  one-cycle pulse when a completed frame is discarded
- dropped_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset state: all outputs 0. Write col/row = 0, wr_bank = 1, rd_bank = 0, pending = 0, armed = 1.
- Write position counter: advances only on edge_valid.
  - col 0..EDGE_W-1; at col wrap, row increments.
  - At (EDGE_W-1, EDGE_H-1) both wrap to 0.
  - Write address is an incremental counter 0..EDGE_W*EDGE_H-1, reset with the position counter. No multiplier on the write side.
- Bank memory: two banks of EDGE_W*EDGE_H bits, synchronous read with 1-cycle latency. Writes are accepted only when armed = 1.
- Write control:
  - armed is set when pending = 0 and the position counter is at (0,0). It is cleared when the last pixel of a frame is written. This ensures only whole frames are written.
  - Last pixel written while armed: pending <= 1, armed <= 0.
  - A full frame that passes while pending = 1 is discarded: at its last pixel, frame_drop pulses and dropped_cnt increments, holding at 255.
- Swap:
  - Occurs on the cycle where pix_x == 0 && pix_y == 0 and pending = 1.
  - rd_bank <= wr_bank, wr_bank <= ~wr_bank, pending <= 0, has_frame <= 1.
  - Writer re-arms at the next (0,0) position.
  - If a last-pixel write and a swap coincide, the write completes into the old wr_bank first; pending is then set and that bank is swapped at the next (0,0).
- Read pipeline, fixed 2-cycle latency:
  - Stage 1: in_win = X_START <= pix_x < X_START+EDGE_W and Y_START <= pix_y < Y_START+EDGE_H. Read address = (pix_y-Y_START)*EDGE_W + (pix_x-X_START) from rd_bank; address is don't-care when outside the window.
  - Stage 2: pix_data <= !in_win_d ? OUT_COLOR : !has_frame ? BG_COLOR : bit ? FG_COLOR : BG_COLOR.
  - Coordinates at or beyond HOR_SCREEN/VERT_SCREEN yield OUT_COLOR.
- Reset mid-operation: any partial frame is lost, has_frame = 0, and all counters restart from 0. Memory contents are not cleared; they are masked by has_frame.

Test Plan:
- Reset, then request (321,161), (0,0), (900,10) -> pix_data 16'h0000, 16'h001F, 16'h001F at 2-cycle latency; has_frame = 0, dropped_cnt = 0.
- Write one frame of 24964 valid pixels with 1 only at (0,0) and (157,157), then drive (0,0) -> has_frame = 1. Then (321,161) -> FFFF, (322,161) -> 0000, (478,318) -> FFFF, (320,161) -> 001F, (479,318) -> 001F.
- Write two complete frames with no (0,0) request between them -> frame_drop pulses once at the second frame's last pixel, dropped_cnt = 1. After swap, the display shows frame 1's pattern.
- After a swap, write a new frame with 1 at (5,5) but do not request (0,0) -> (326,166) still reads the old bank. After (0,0), it reads FFFF.
- Send a frame with random edge_valid gaps (about 50% duty) -> result is identical to the gap-free case; no address advance on invalid cycles.
- Write 1000 pixels, assert rst for 1 cycle, then write a full frame and swap -> has_frame was 0 after reset, and the stored image aligns with the first post-reset pixel at (321,161).
